// File: rtl/udiv_check_mul.sv
// Sequential shift-add multiplier: rebuilds a dividend as q*d+r from divider results.
// Flags results above 8 bits and remainders not below the divisor.
module udiv_check_mul (
  input  logic        CLK,
  input  logic        iRESET,
  input  logic [7:0]  iQUOTIENT,
  input  logic [3:0]  iDIVISOR,
  input  logic [3:0]  iREMAINDER,
  input  logic        iMULVLD,
  output logic [11:0] oPRODUCT,
  output logic        oOVF,
  output logic        oINVALID,
  output logic        oBUSY,
  output logic        oDONE
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]  rState;
  logic        rVldD1;
  logic        rVldD2;
  logic        wStart;
  logic [11:0] rAcc;
  logic [11:0] rMcand;
  logic [3:0]  rMplier;
  logic [1:0]  rCount;
  logic        rInv;

  assign wStart = rVldD1 & ~rVldD2;
  assign oBUSY  = (rState != IDLE);

  always_ff @(posedge CLK) begin
    if (iRESET) begin
      rState   <= IDLE;
      rVldD1   <= 1'b0;
      rVldD2   <= 1'b0;
      rAcc     <= '0;
      rMcand   <= '0;
      rMplier  <= '0;
      rCount   <= '0;
      rInv     <= 1'b0;
      oPRODUCT <= '0;
      oOVF     <= 1'b0;
      oINVALID <= 1'b0;
      oDONE    <= 1'b0;
    end else begin
      rVldD1 <= iMULVLD;
      rVldD2 <= rVldD1;
      oDONE  <= 1'b0;
      // a fresh start aborts whatever is in flight
      if (wStart) begin
        rState   <= CALC;
        rMcand   <= {4'b0, iQUOTIENT};
        rMplier  <= iDIVISOR;
        rAcc     <= {8'b0, iREMAINDER};
        rInv     <= (iREMAINDER >= iDIVISOR);
        rCount   <= '0;
        oPRODUCT <= '0;
        oOVF     <= 1'b0;
        oINVALID <= 1'b0;
      end else begin
        unique case (1'b1)
          (rState == CALC): begin
            if (rMplier[0])
              rAcc <= rAcc + rMcand;
            rMcand  <= rMcand << 1;
            rMplier <= rMplier >> 1;
            rCount  <= rCount + 2'd1;
            if (rCount == 2'd3)
              rState <= FIN;
          end
          (rState == FIN): begin
            oPRODUCT <= rAcc;
            oOVF     <= |rAcc[11:8];
            oINVALID <= rInv;
            oDONE    <= 1'b1;
            rState   <= IDLE;
          end
          default: rState <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udiv_check_mul.sv
// Bench for udiv_check_mul: scenario tasks compared against q*d+r arithmetic.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_udiv_check_mul;

  logic        CLK = 1'b0;
  logic        iRESET = 1'b1;
  logic [7:0]  iQUOTIENT = '0;
  logic [3:0]  iDIVISOR = '0;
  logic [3:0]  iREMAINDER = '0;
  logic        iMULVLD = 1'b0;
  logic [11:0] oPRODUCT;
  logic        oOVF;
  logic        oINVALID;
  logic        oBUSY;
  logic        oDONE;

  int nPass = 0;
  int nTotal = 0;

  always #5 CLK = ~CLK;

  udiv_check_mul dut (
    .CLK(CLK), .iRESET(iRESET),
    .iQUOTIENT(iQUOTIENT), .iDIVISOR(iDIVISOR),
    .iREMAINDER(iREMAINDER), .iMULVLD(iMULVLD),
    .oPRODUCT(oPRODUCT), .oOVF(oOVF),
    .oINVALID(oINVALID), .oBUSY(oBUSY),
    .oDONE(oDONE)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one request at the next edge (E0) and checks timing and result.
  task automatic do_op(input int q, input int d, input int r,
                       input string name);
    int exp;
    int doneAt;
    int nDone;
    int nBusy;
    logic [11:0] prod;
    logic ovf;
    logic inv;
    exp = q * d + r;
    iQUOTIENT = 8'(q);
    iDIVISOR = 4'(d);
    iREMAINDER = 4'(r);
    iMULVLD = 1'b1;
    doneAt = -1;
    nDone = 0;
    nBusy = 0;
    prod = '0;
    ovf = 1'b0;
    inv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 1) iMULVLD = 1'b0;
      if (oBUSY) nBusy++;
      if (oDONE) begin
        nDone++;
        doneAt = i;
        prod = oPRODUCT;
        ovf = oOVF;
        inv = oINVALID;
      end
    end
    nTotal++;
    if (doneAt !== 6 || nDone !== 1)
      $display("FAIL %s done: at E%0d count %0d, want E6 count 1",
               name, doneAt, nDone);
    else nPass++;
    nTotal++;
    if (nBusy !== 5)
      $display("FAIL %s busy: %0d cycles, want 5", name, nBusy);
    else nPass++;
    nTotal++;
    if (prod !== 12'(exp) || oPRODUCT !== 12'(exp))
      $display("FAIL %s product: %0d held %0d, want %0d",
               name, prod, oPRODUCT, exp);
    else nPass++;
    nTotal++;
    if (ovf !== (exp > 255) || inv !== (r >= d))
      $display("FAIL %s flags: ovf %b inv %b, want ovf %b inv %b",
               name, ovf, inv, exp > 255, r >= d);
    else nPass++;
  endtask

  task automatic test_reset();
    int nDone;
    int doneAt;
    iRESET = 1'b1;
    iMULVLD = 1'b1;
    iQUOTIENT = 8'd100;
    iDIVISOR = 4'd7;
    iREMAINDER = 4'd3;
    tick();
    iQUOTIENT = 8'($urandom);
    tick();
    nTotal++;
    if ({oPRODUCT, oOVF, oINVALID, oBUSY, oDONE} !== 16'h0)
      $display("FAIL reset outputs: prod %0d ovf %b inv %b busy %b done %b, want 0",
               oPRODUCT, oOVF, oINVALID, oBUSY, oDONE);
    else nPass++;
    iQUOTIENT = 8'd100;
    iRESET = 1'b0;
    nDone = 0;
    doneAt = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 1) iMULVLD = 1'b0;
      if (oDONE) begin
        nDone++;
        doneAt = i;
      end
    end
    nTotal++;
    if (nDone !== 1 || doneAt !== 6)
      $display("FAIL reset_release done: count %0d at E%0d, want 1 at E6",
               nDone, doneAt);
    else nPass++;
    nTotal++;
    if (oPRODUCT !== 12'd703 || oINVALID !== 1'b0 || oOVF !== 1'b1)
      $display("FAIL reset_release result: %0d ovf %b inv %b, want 703 1 0",
               oPRODUCT, oOVF, oINVALID);
    else nPass++;
  endtask

  task automatic test_basic();
    do_op(84, 3, 2, "basic");
  endtask

  task automatic test_boundary();
    do_op(255, 15, 15, "max");
    tick();
    do_op(17, 15, 0, "fit255");
    tick();
    do_op(0, 0, 15, "zero_q");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      do_op(int'($urandom_range(255)), int'($urandom_range(15)),
            int'($urandom_range(15)), "random");
      tick();
    end
  endtask

  task automatic test_div_zero();
    int nDone;
    iQUOTIENT = 8'd200;
    iDIVISOR = 4'd0;
    iREMAINDER = 4'd0;
    iMULVLD = 1'b1;
    nDone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (oDONE) nDone++;
    end
    iMULVLD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (oDONE) nDone++;
    end
    nTotal++;
    if (nDone !== 1)
      $display("FAIL div0 held: %0d done pulses, want 1", nDone);
    else nPass++;
    nTotal++;
    if (oPRODUCT !== 12'd0 || oINVALID !== 1'b1 || oOVF !== 1'b0)
      $display("FAIL div0 result: %0d ovf %b inv %b, want 0 0 1",
               oPRODUCT, oOVF, oINVALID);
    else nPass++;
  endtask

  task automatic test_restart();
    int nDone;
    int doneAt;
    logic [11:0] midProd;
    iQUOTIENT = 8'd255;
    iDIVISOR = 4'd15;
    iREMAINDER = 4'd0;
    iMULVLD = 1'b1;
    nDone = 0;
    doneAt = -1;
    midProd = 12'hfff;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 2) iMULVLD = 1'b0;
      if (i == 3) begin
        iMULVLD = 1'b1;
        iQUOTIENT = 8'd19;
        iDIVISOR = 4'd13;
        iREMAINDER = 4'd8;
      end
      if (i == 6) iMULVLD = 1'b0;
      if (i == 5) midProd = oPRODUCT;
      if (oDONE) begin
        nDone++;
        doneAt = i;
      end
    end
    nTotal++;
    if (nDone !== 1 || doneAt !== 10)
      $display("FAIL restart done: count %0d at E%0d, want 1 at E10",
               nDone, doneAt);
    else nPass++;
    nTotal++;
    if (midProd !== 12'd0)
      $display("FAIL restart clear: product %0d after capture, want 0", midProd);
    else nPass++;
    nTotal++;
    if (oPRODUCT !== 12'd255 || oINVALID !== 1'b0 || oOVF !== 1'b0)
      $display("FAIL restart result: %0d ovf %b inv %b, want 255 0 0",
               oPRODUCT, oOVF, oINVALID);
    else nPass++;
  endtask

  task automatic test_reset_mid();
    int nDone;
    iQUOTIENT = 8'd200;
    iDIVISOR = 4'd15;
    iREMAINDER = 4'd15;
    iMULVLD = 1'b1;
    nDone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (oDONE) nDone++;
      if (i == 2) begin
        iRESET = 1'b1;
        iMULVLD = 1'b0;
      end
    end
    tick();
    nTotal++;
    if ({oPRODUCT, oOVF, oINVALID, oBUSY, oDONE} !== 16'h0)
      $display("FAIL reset_mid outputs: prod %0d busy %b done %b, want 0",
               oPRODUCT, oBUSY, oDONE);
    else nPass++;
    iRESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (oDONE) nDone++;
    end
    nTotal++;
    if (nDone !== 0)
      $display("FAIL reset_mid lost: %0d done pulses, want 0", nDone);
    else nPass++;
    do_op(127, 2, 1, "after_reset");
  endtask

  initial begin
    tick();
    test_reset();
    tick();
    test_basic();
    tick();
    test_boundary();
    tick();
    test_random();
    test_div_zero();
    tick();
    test_restart();
    tick();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
